dispense_controller: RTL

//  Consumes the one-cycle press pulses from the button edge detectors and runs the dispenser.

---
 rtl/dispense_controller_pkg.sv | 11 +
 rtl/dispense_controller_step_timer.sv | 32 +++
 rtl/dispense_controller.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/dispense_controller_pkg.sv
// rtl/dispense_controller_pkg.sv - shared state encoding for the water dispenser controller.
package dispense_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_DISPENSING = 2'd1,
    ST_DONE       = 2'd2,
    ST_FAULT      = 2'd3
  } state_t;

endpackage

// File: rtl/dispense_controller_step_timer.sv
// rtl/dispense_controller_step_timer.sv - step prescaler; one-cycle tick on the last count of each step.
module step_timer #(
  parameter int TICKS_PER_STEP = 5000000
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tick
);

  localparam int CW = $clog2(TICKS_PER_STEP);
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_STEP - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] r_count;
  logic          w_wrap;

  assign w_wrap = i_enable && (r_count == LAST);
  assign o_tick = w_wrap;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear || w_wrap) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + ONE;
    end
  end

endmodule

// File: rtl/dispense_controller.sv
// rtl/dispense_controller.sv - dispenser FSM: cup size, timed valve, cancel and dry-tank fault.
module dispense_controller
  import dispense_controller_pkg::*;
#(
  parameter int TICKS_PER_STEP = 5000000,
  parameter int SMALL_STEPS    = 30,
  parameter int LARGE_STEPS    = 60,
  parameter int STEP_WIDTH     = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  size_pressed,
  input  logic                  start_pressed,
  input  logic                  stop_pressed,
  input  logic                  tank_empty,
  output logic                  valve_open,
  output logic                  size_large,
  output logic                  busy,
  output logic                  done,
  output logic                  fault,
  output logic [STEP_WIDTH-1:0] remaining_steps
);

  localparam logic [STEP_WIDTH-1:0] SMALL_LOAD = STEP_WIDTH'(SMALL_STEPS);
  localparam logic [STEP_WIDTH-1:0] LARGE_LOAD = STEP_WIDTH'(LARGE_STEPS);
  localparam logic [STEP_WIDTH-1:0] STEP_ONE   = STEP_WIDTH'(1);

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_valve_open;
  logic                  r_size_large;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_fault;
  logic [STEP_WIDTH-1:0] r_remaining;

  logic                  w_size_next;
  logic [STEP_WIDTH-1:0] w_remaining_next;
  logic                  w_load;
  logic                  w_timer_en;
  logic                  w_tick;

  assign w_timer_en = (r_state == ST_DISPENSING);

  step_timer #(
    .TICKS_PER_STEP (TICKS_PER_STEP)
  ) u_step_timer (
    .clock    (clock),
    .reset    (reset),
    .i_clear  (w_load),
    .i_enable (w_timer_en),
    .o_tick   (w_tick)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_size_next      = r_size_large;
    w_remaining_next = r_remaining;
    w_load           = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // stop outranks start, and start suppresses a same-cycle size toggle
        if (stop_pressed) begin
          w_state_next = ST_IDLE;
        end else if (start_pressed && tank_empty) begin
          w_state_next = ST_FAULT;
        end else if (start_pressed) begin
          w_state_next     = ST_DISPENSING;
          w_load           = 1'b1;
          w_remaining_next = r_size_large ? LARGE_LOAD : SMALL_LOAD;
        end else if (size_pressed) begin
          w_size_next = ~r_size_large;
        end
      end
      ST_DISPENSING: begin
        if (tank_empty) begin
          w_state_next     = ST_FAULT;
          w_remaining_next = '0;
        end else if (stop_pressed) begin
          w_state_next     = ST_IDLE;
          w_remaining_next = '0;
        end else if (w_tick) begin
          if (r_remaining == STEP_ONE) begin
            w_state_next     = ST_DONE;
            w_remaining_next = '0;
          end else begin
            w_remaining_next = r_remaining - STEP_ONE;
          end
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      ST_FAULT: begin
        if (stop_pressed && !tank_empty) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next     = ST_IDLE;
        w_remaining_next = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valve_open <= 1'b0;
      r_size_large <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_fault      <= 1'b0;
      r_remaining  <= '0;
    end else begin
      r_valve_open <= (w_state_next == ST_DISPENSING);
      r_size_large <= w_size_next;
      r_busy       <= (w_state_next == ST_DISPENSING);
      r_done       <= (w_state_next == ST_DONE);
      r_fault      <= (w_state_next == ST_FAULT);
      r_remaining  <= w_remaining_next;
    end
  end

  assign valve_open      = r_valve_open;
  assign size_large      = r_size_large;
  assign busy            = r_busy;
  assign done            = r_done;
  assign fault           = r_fault;
  assign remaining_steps = r_remaining;

endmodule
